// File: rtl/muller_c_pkg.sv
// Shared types for the Muller C-element exercise arbiter.
// FSM states and requester status codes.
package muller_c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    RISE_A,
    RISE_B,
    FALL_A,
    FALL_B,
    RECOVER,
    DONE
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_HOLD = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

endpackage

// File: rtl/muller_c_sync.sv
// Flop-chain synchronizer for the asynchronous C-element output.
// Clears to 0 on async reset.
module muller_c_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // shift the async input through STAGES flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/muller_c_handshake_arb.sv
// Round-robin arbiter sharing one C-element stage; drives a
// 4-phase a/b exercise and reports ok / hold / timeout.
module muller_c_handshake_arb
  import muller_c_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SKEW_CYC    = 4,
  parameter int TIMEOUT     = 64,
  localparam int CNT_W      = $clog2(TIMEOUT+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [1:0]       status,
  output logic             busy,
  output logic             celem_a,
  output logic             celem_b,
  input  logic             celem_c
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT-1);
  localparam logic [CNT_W-1:0] SKEW_LAST = CNT_W'(SKEW_CYC-1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         err_q, err_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               c_s;
  logic               win_ok;
  logic [PTR_W-1:0]   win_idx;
  logic               tmo;
  logic               skew_end;

  muller_c_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (celem_c),
    .q_o   (c_s)
  );

  assign tmo      = (cnt_q == TMO_LAST);
  assign skew_end = (cnt_q == SKEW_LAST);

  // round-robin search starting just after the last winner
  always_comb begin
    win_ok  = 1'b0;
    win_idx = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % N_REQ;
      if (!win_ok && req[j]) begin
        win_ok  = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  // next state, error capture, grant and a/b drive
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (win_ok) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = win_idx;
          state_d        = RISE_A;
        end else begin
          state_d = IDLE;
        end
      end
      RISE_A: begin
        if (c_s) begin
          err_d   = ST_HOLD;
          state_d = RECOVER;
        end else if (skew_end) begin
          state_d = RISE_B;
        end
      end
      RISE_B: begin
        if (c_s) begin
          state_d = FALL_A;
        end else if (tmo) begin
          err_d   = ST_TMO;
          state_d = RECOVER;
        end
      end
      FALL_A: begin
        if (!c_s) begin
          err_d   = ST_HOLD;
          state_d = RECOVER;
        end else if (skew_end) begin
          state_d = FALL_B;
        end
      end
      FALL_B: begin
        if (!c_s) begin
          state_d = DONE;
        end else if (tmo) begin
          err_d   = ST_TMO;
          state_d = DONE;
        end
      end
      RECOVER: if (!c_s || tmo) state_d = DONE;
      DONE: begin
        gnt_d   = '0;
        err_d   = ST_OK;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // per-state counter, saturating rather than wrapping
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else cnt_d = cnt_q + 1'b1;

    // a/b follow the state being entered so they are flop outputs
    a_d = 1'b0;
    b_d = 1'b0;
    unique case (state_d)
      RISE_A: a_d = 1'b1;
      RISE_B: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      FALL_A: b_d = 1'b1;
      default: ;
    endcase
  end

  // state, counter, pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(N_REQ-1);
      gnt_q   <= '0;
      err_q   <= ST_OK;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == DONE) ? gnt_q : '0;
  assign status  = (state_q == DONE) ? err_q : ST_OK;
  assign busy    = (state_q != IDLE);
  assign celem_a = a_q;
  assign celem_b = b_q;

endmodule

// File: tb/tb_muller_c_handshake_arb.sv
// Directed bench for muller_c_handshake_arb with a
// behavioural C-element (ideal / stuck-0 / OR) model.
module tb_muller_c_handshake_arb;
  import muller_c_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt, done;
  logic [1:0] status;
  logic       busy, celem_a, celem_b, celem_c;

  always #5 clk = ~clk;

  muller_c_handshake_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .done    (done),
    .status  (status),
    .busy    (busy),
    .celem_a (celem_a),
    .celem_b (celem_b),
    .celem_c (celem_c)
  );

  // model: 0 ideal C, 1 stuck at 0, 2 OR gate; dly cycles delay
  int          mode = 0;
  int          dly  = 3;
  logic        c_st = 1'b0;
  logic [15:0] hist = '0;
  logic        c_nxt;

  always_comb begin
    case (mode)
      1:       c_nxt = 1'b0;
      2:       c_nxt = celem_a | celem_b;
      default: c_nxt = (celem_a & celem_b) | (c_st & (celem_a | celem_b));
    endcase
  end

  always @(posedge clk) begin
    c_st <= c_nxt;
    hist <= {hist[14:0], c_nxt};
  end

  assign celem_c = (dly == 0) ? c_nxt : hist[dly-1];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    int         mode;
    int         dly;
    logic [3:0] gnt;
    logic [1:0] st;
    int         a_only;
    int         ab;
    logic [3:0] req_after;
  } vec_t;

  vec_t vecs[7];

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_a_only = 0;
  int n_ab = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (|done) n_done++;
    if (celem_a && !celem_b) n_a_only++;
    if (celem_a && celem_b) n_ab++;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (20) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_gnt(input string nm);
    int t;
    t = 0;
    while (gnt == '0 && t < 20) begin
      step();
      t++;
    end
    if (t >= 20) check({nm, ".gnt_wait"}, 1, 0);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int t;
    logic [3:0] g;
    logic stable;
    mode = v.mode;
    dly = v.dly;
    req = v.req;
    n_a_only = 0;
    n_ab = 0;
    wait_gnt(nm);
    check({nm, ".gnt"}, gnt, v.gnt);
    g = gnt;
    stable = 1'b1;
    t = 0;
    while (done == '0 && t < 400) begin
      if (gnt !== g) stable = 1'b0;
      step();
      t++;
    end
    check({nm, ".done"}, done, v.gnt);
    check({nm, ".status"}, status, v.st);
    check({nm, ".gnt_held"}, {stable, gnt}, {1'b1, g});
    check({nm, ".busy"}, busy, 1);
    if (v.a_only >= 0) check({nm, ".a_only_cyc"}, n_a_only, v.a_only);
    if (v.ab >= 0) check({nm, ".ab_cyc"}, n_ab, v.ab);
    req = v.req_after;
    step();
    check({nm, ".done_pulse"}, {done, status}, 6'd0);
    check({nm, ".gnt_clr"}, gnt, 0);
  endtask

  initial begin
    int t;
    int snap;
    vecs[0] = '{1'b1, 4'b0001, 0, 3, 4'b0001, ST_OK,   4, -1, 4'b0000};
    vecs[1] = '{1'b1, 4'b0101, 0, 3, 4'b0001, ST_OK,   4, -1, 4'b0101};
    vecs[2] = '{1'b0, 4'b0101, 0, 3, 4'b0100, ST_OK,   4, -1, 4'b0101};
    vecs[3] = '{1'b0, 4'b0101, 0, 3, 4'b0001, ST_OK,   4, -1, 4'b0101};
    vecs[4] = '{1'b0, 4'b0101, 0, 3, 4'b0100, ST_OK,   4, -1, 4'b0000};
    vecs[5] = '{1'b1, 4'b0010, 1, 3, 4'b0010, ST_TMO,  4, 64, 4'b0000};
    vecs[6] = '{1'b1, 4'b1000, 2, 0, 4'b1000, ST_HOLD, 3, 0,  4'b0000};

    repeat (3) step();
    check("reset.outs", {gnt, done, status, busy, celem_a, celem_b},
          14'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst) do_reset();
      run_txn(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].req_after == '0) begin
        step();
        check($sformatf("vec%0d.idle", i), busy, 0);
      end
    end

    // reset in the middle of RISE_B aborts without a done pulse
    do_reset();
    mode = 0;
    dly = 3;
    req = 4'b0011;
    wait_gnt("rst");
    check("rst.first_gnt", gnt, 4'b0001);
    t = 0;
    while (!(celem_a && celem_b) && t < 40) begin
      step();
      t++;
    end
    check("rst.in_rise_b", {celem_a, celem_b}, 2'b11);
    step();
    snap = n_done;
    rst_n = 1'b0;
    #1;
    check("rst.async_outs", {gnt, done, status, busy, celem_a, celem_b},
          14'd0);
    repeat (10) step();
    rst_n = 1'b1;
    run_txn('{1'b0, 4'b0011, 0, 3, 4'b0001, ST_OK, 4, -1, 4'b0010},
            "rst.t0");
    check("rst.no_done_pulse", n_done - snap, 1);
    run_txn('{1'b0, 4'b0010, 0, 3, 4'b0010, ST_OK, 4, -1, 4'b0000},
            "rst.t1");

    // request withdrawn during FALL_A still completes
    do_reset();
    mode = 0;
    dly = 3;
    req = 4'b0100;
    wait_gnt("drop");
    check("drop.gnt", gnt, 4'b0100);
    t = 0;
    while (!(!celem_a && celem_b) && t < 40) begin
      step();
      t++;
    end
    check("drop.in_fall_a", {celem_a, celem_b}, 2'b01);
    req = 4'b1001;
    t = 0;
    while (done == '0 && t < 100) begin
      step();
      t++;
    end
    check("drop.done", done, 4'b0100);
    check("drop.status", status, ST_OK);
    step();
    run_txn('{1'b0, 4'b1001, 0, 3, 4'b1000, ST_OK, 4, -1, 4'b0001},
            "drop.next");
    run_txn('{1'b0, 4'b0001, 0, 3, 4'b0001, ST_OK, 4, -1, 4'b0000},
            "drop.last");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
